// File: rtl/l1_i_cache_param_if.sv
// Fetch-side and refill-side signal bundle for the parameterised L1 instruction cache.
// The cache connects through the slave modport; the core/L2 model uses master.
interface l1_i_cache_param_if #(
  parameter int SETS      = 32,
  parameter int LINE_BITS = 512
);
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  // core fetch side
  logic                 read_C_L1;
  logic [TAG_W-1:0]     tag_C_L1;
  logic [IDX_W-1:0]     index_C_L1;
  logic [OFF_W-1:0]     offset;
  logic                 flush;
  logic                 stall;
  logic [31:0]          read_data_L1_C;
  // L2 refill side
  logic                 read_L1_L2;
  logic [TAG_W-1:0]     tag_L1_L2;
  logic [IDX_W-1:0]     index_L1_L2;
  logic                 ready_L2_L1;
  logic [LINE_BITS-1:0] read_data_L2_L1;
  // performance counters
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  modport slave (
    input  read_C_L1, tag_C_L1, index_C_L1, offset, flush, ready_L2_L1, read_data_L2_L1,
    output stall, read_data_L1_C, read_L1_L2, tag_L1_L2, index_L1_L2, hit_count, miss_count
  );

  modport master (
    output read_C_L1, tag_C_L1, index_C_L1, offset, flush, ready_L2_L1, read_data_L2_L1,
    input  stall, read_data_L1_C, read_L1_L2, tag_L1_L2, index_L1_L2, hit_count, miss_count
  );
endinterface

// File: rtl/l1_i_cache_param.sv
// Set-associative L1 instruction cache with tree-PLRU replacement.
// Hits are served combinationally in IDLE; a miss parks the FSM in MISS and
// holds a registered line request to L2 until the refill arrives.
module l1_i_cache_param #(
  parameter int WAYS      = 2,
  parameter int SETS      = 32,
  parameter int LINE_BITS = 512
) (
  input  logic               clk,
  input  logic               rst,
  l1_i_cache_param_if.slave  bus
);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_BITS / 32);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LVL    = $clog2(WAYS);
  // With a single way the tree has no nodes; the one spare bit stays constant 0.
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_e;

  state_e               state_q;
  logic                 valid_q [WAYS][SETS];
  logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_BITS-1:0] line_q  [WAYS][SETS];
  logic [PLRU_W-1:0]    plru_q  [SETS];
  logic [TAG_W-1:0]     miss_tag_q;
  logic [IDX_W-1:0]     miss_idx_q;
  logic [WAY_W-1:0]     victim_q;
  logic                 read_l2_q;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;

  logic                 hit_any_s, inv_any_s, hit_s, miss_start_s, fill_s, stall_s;
  logic [WAY_W-1:0]     hit_way_s, inv_way_s, victim_s;
  logic [WSEL_W-1:0]    wsel_s;
  logic [LINE_BITS-1:0] hit_line_s;
  logic [31:0]          hit_word_s;
  logic                 offset_unused_s;

  // Walk the tree from the root: node bit 0 points left, 1 points right (heap numbering).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    int node;
    logic [PLRU_W-1:0] sh;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      sh   = p >> (node - 1);
      node = 2 * node + int'(sh[0]);
    end
    return WAY_W'(node - WAYS);
  endfunction

  // Mark a way most-recent: every node on its path points to the other subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] r;
    int node, parent;
    logic away;
    r    = p;
    node = int'(way) + WAYS;
    for (int l = 0; l < LVL; l++) begin
      parent = node / 2;
      away   = ((node % 2) == 0);
      r      = (r & ~(PLRU_W'(1'b1) << (parent - 1))) | (PLRU_W'(away) << (parent - 1));
      node   = parent;
    end
    return r;
  endfunction

  // Tag compare across ways, lowest invalid way, and word select for the hit way.
  always_comb begin
    hit_any_s = 1'b0;
    hit_way_s = '0;
    inv_any_s = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][bus.index_C_L1] && (tag_q[w][bus.index_C_L1] == bus.tag_C_L1)) begin
        hit_any_s = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_any_s = hit_any_s;
      end
      if (!valid_q[w][bus.index_C_L1]) begin
        inv_any_s = 1'b1;
        inv_way_s = WAY_W'(w);
      end else begin
        inv_any_s = inv_any_s;
      end
    end
    victim_s   = inv_any_s ? inv_way_s : plru_victim(plru_q[bus.index_C_L1]);
    wsel_s     = bus.offset[OFF_W-1:2];
    hit_line_s = line_q[hit_way_s][bus.index_C_L1];
    hit_word_s = hit_line_s[{wsel_s, 5'b00000} +: 32];
  end

  // Byte-within-word bits do not take part in instruction fetch.
  assign offset_unused_s = ^bus.offset[1:0];

  assign hit_s        = (state_q == IDLE) && bus.read_C_L1 && hit_any_s;
  assign miss_start_s = (state_q == IDLE) && bus.read_C_L1 && !hit_any_s && !bus.flush;
  assign fill_s       = (state_q == MISS) && bus.ready_L2_L1 && !bus.flush;
  assign stall_s      = !rst && (bus.flush || (state_q == MISS) || (bus.read_C_L1 && !hit_any_s));

  // Saturating hit/miss counters; a flush cycle is neither a served hit nor a miss entry.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_s && !bus.flush && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (miss_start_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Controller: IDLE/MISS sequencing, valid bits, PLRU, latched refill address, counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      read_l2_q  <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (bus.flush) begin
        // Flush beats everything, including a refill landing this cycle.
        state_q   <= IDLE;
        read_l2_q <= 1'b0;
        for (int s = 0; s < SETS; s++) begin
          plru_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (hit_s) begin
              plru_q[bus.index_C_L1] <= plru_touch(plru_q[bus.index_C_L1], hit_way_s);
            end else if (bus.read_C_L1) begin
              miss_tag_q <= bus.tag_C_L1;
              miss_idx_q <= bus.index_C_L1;
              victim_q   <= victim_s;
              read_l2_q  <= 1'b1;
              state_q    <= MISS;
            end
          end
          MISS: begin
            if (bus.ready_L2_L1) begin
              valid_q[victim_q][miss_idx_q] <= 1'b1;
              plru_q[miss_idx_q]            <= plru_touch(plru_q[miss_idx_q], victim_q);
              read_l2_q                     <= 1'b0;
              state_q                       <= IDLE;
            end
          end
          default: begin
            state_q   <= IDLE;
            read_l2_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tag and line payload storage, written only when a refill completes.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
      line_q[victim_q][miss_idx_q] <= bus.read_data_L2_L1;
    end
  end

  assign bus.stall          = stall_s;
  assign bus.read_data_L1_C = (hit_s && !stall_s) ? hit_word_s : 32'h0;
  assign bus.read_L1_L2     = read_l2_q;
  assign bus.tag_L1_L2      = miss_tag_q;
  assign bus.index_L1_L2    = miss_idx_q;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_l1_i_cache_param.sv
// Bench for l1_i_cache_param (WAYS=2, SETS=32, LINE_BITS=512): directed scenarios plus a
// randomised fetch stream checked against a per-set LRU cache model.
module tb_l1_i_cache_param;
  localparam int WAYS = 2, SETS = 32, LINE_BITS = 512;
  localparam int OFF_W = 6, IDX_W = 5, TAG_W = 21, WORDS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_i_cache_param_if #(.SETS(SETS), .LINE_BITS(LINE_BITS)) bus ();
  l1_i_cache_param #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model: 2-way sets with true LRU (identical to tree-PLRU for 2 ways)
  logic                 m_valid [WAYS][SETS];
  logic [TAG_W-1:0]     m_tag   [WAYS][SETS];
  logic [LINE_BITS-1:0] m_line  [WAYS][SETS];
  int                   m_lru   [SETS];
  logic [31:0]          m_hits, m_misses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.read_C_L1 = 1'b0; bus.tag_C_L1 = '0; bus.index_C_L1 = '0; bus.offset = '0;
    bus.flush = 1'b0; bus.ready_L2_L1 = 1'b0; bus.read_data_L2_L1 = '0;
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    m_hits = 32'd0;
    m_misses = 32'd0;
  endtask

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete fetch as seen by the core: expected hit flag and returned word.
  task automatic model_access(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                              input logic [OFF_W-1:0] off, input logic [LINE_BITS-1:0] ln,
                              output logic eh, output logic [31:0] ew);
    int w;
    w = -1;
    for (int k = 0; k < WAYS; k++)
      if (w < 0 && m_valid[k][ix] && m_tag[k][ix] == t) w = k;
    eh = (w >= 0);
    if (w < 0) begin
      for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[k][ix]) w = k;
      if (w < 0) w = m_lru[ix];
      m_valid[w][ix] = 1'b1;
      m_tag[w][ix] = t;
      m_line[w][ix] = ln;
      if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
    end
    if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
    m_lru[ix] = 1 - w;
    ew = m_line[w][ix][int'(off[OFF_W-1:2])*32 +: 32];
  endtask

  // Core + L2 stimulus for one fetch; reports the first-cycle stall, the delivered word
  // and whether the refill handshake looked right on every cycle it was observed.
  task automatic fetch(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                       input logic [OFF_W-1:0] off, input logic [LINE_BITS-1:0] ln,
                       input int delay, output logic first_stall, output logic [31:0] data,
                       output logic proto_ok);
    proto_ok = 1'b1;
    data = 32'h0;
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = t; bus.index_C_L1 = ix; bus.offset = off;
    #1;
    first_stall = bus.stall;
    if (!first_stall) begin
      data = bus.read_data_L1_C;
    end else begin
      if (bus.read_data_L1_C !== 32'h0) proto_ok = 1'b0;
      tick();
      for (int c = 0; c <= delay; c++) begin
        if (c == delay) begin
          bus.ready_L2_L1 = 1'b1;
          bus.read_data_L2_L1 = ln;
        end
        #1;
        if (bus.read_L1_L2 !== 1'b1 || bus.tag_L1_L2 !== t || bus.index_L1_L2 !== ix ||
            bus.stall !== 1'b1 || bus.read_data_L1_C !== 32'h0) proto_ok = 1'b0;
        tick();
      end
      bus.ready_L2_L1 = 1'b0;
      bus.read_data_L2_L1 = '0;
      #1;
      if (bus.stall !== 1'b0 || bus.read_L1_L2 !== 1'b0) proto_ok = 1'b0;
      data = bus.read_data_L1_C;
    end
    tick();
    bus.read_C_L1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h5;
    model_reset();
    tick(); tick();
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.read_L1_L2 !== 1'b0) $display("FAIL rst_read_l2 got %0b want 0", bus.read_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.read_data_L1_C !== 32'h0) $display("FAIL rst_data got %h want 0", bus.read_data_L1_C); else pass_cnt++;
    total_cnt++; if (bus.tag_L1_L2 !== '0) $display("FAIL rst_tag got %h want 0", bus.tag_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.index_L1_L2 !== '0) $display("FAIL rst_idx got %h want 0", bus.index_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.hit_count !== 32'd0) $display("FAIL rst_hits got %0d want 0", bus.hit_count); else pass_cnt++;
    total_cnt++; if (bus.miss_count !== 32'd0) $display("FAIL rst_misses got %0d want 0", bus.miss_count); else pass_cnt++;
    rst = 1'b0;
    bus.read_C_L1 = 1'b0;
    #1;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL idle_stall got %0b want 0", bus.stall); else pass_cnt++;
    tick();
    total_cnt++; if (bus.read_L1_L2 !== 1'b0) $display("FAIL idle_read_l2 got %0b want 0", bus.read_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.miss_count !== 32'd0) $display("FAIL idle_misses got %0d want 0", bus.miss_count); else pass_cnt++;
  endtask

  task automatic test_cold_fetch();
    logic [LINE_BITS-1:0] ln;
    logic eh;
    logic [31:0] ew;
    ln = rand_line();
    ln[2*32 +: 32] = 32'hDEAD_BEEF;
    model_access(21'h1234, 5'd3, 6'h08, ln, eh, ew);
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h1234; bus.index_C_L1 = 5'd3; bus.offset = 6'h08;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL cold_stall got %0b want 1", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.read_L1_L2 !== 1'b0) $display("FAIL cold_req_early got %0b want 0", bus.read_L1_L2); else pass_cnt++;
    tick();
    total_cnt++; if (bus.read_L1_L2 !== 1'b1) $display("FAIL cold_req got %0b want 1", bus.read_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.tag_L1_L2 !== 21'h1234) $display("FAIL cold_req_tag got %h want 1234", bus.tag_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.index_L1_L2 !== 5'd3) $display("FAIL cold_req_idx got %0d want 3", bus.index_L1_L2); else pass_cnt++;
    bus.ready_L2_L1 = 1'b1; bus.read_data_L2_L1 = ln;
    tick();
    bus.ready_L2_L1 = 1'b0; bus.read_data_L2_L1 = '0;
    #1;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL cold_hit_stall got %0b want 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.read_data_L1_C !== 32'hDEAD_BEEF) $display("FAIL cold_data got %h want deadbeef", bus.read_data_L1_C); else pass_cnt++;
    tick();
    bus.read_C_L1 = 1'b0;
    total_cnt++; if (bus.miss_count !== 32'd1) $display("FAIL cold_misses got %0d want 1", bus.miss_count); else pass_cnt++;
    total_cnt++; if (bus.hit_count !== 32'd1) $display("FAIL cold_hits got %0d want 1", bus.hit_count); else pass_cnt++;
  endtask

  task automatic test_plru();
    logic [TAG_W-1:0] tg [6];
    logic exp_m [6];
    logic eh, fs, ok;
    logic [31:0] ew, d;
    logic [OFF_W-1:0] off;
    tg[0] = 21'h0AAAA; tg[1] = 21'h0BBBB; tg[2] = 21'h0AAAA;
    tg[3] = 21'h0CCCC; tg[4] = 21'h0AAAA; tg[5] = 21'h0BBBB;
    exp_m[0] = 1'b1; exp_m[1] = 1'b1; exp_m[2] = 1'b0;
    exp_m[3] = 1'b1; exp_m[4] = 1'b0; exp_m[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [LINE_BITS-1:0] ln;
      ln = rand_line();
      off = 6'($urandom_range(0, 63));
      model_access(tg[i], 5'd5, off, ln, eh, ew);
      fetch(tg[i], 5'd5, off, ln, 1, fs, d, ok);
      total_cnt++; if (fs !== exp_m[i]) $display("FAIL plru_miss[%0d] got %0b want %0b", i, fs, exp_m[i]); else pass_cnt++;
      total_cnt++; if (d !== ew) $display("FAIL plru_data[%0d] got %h want %h", i, d, ew); else pass_cnt++;
    end
  endtask

  task automatic test_delayed_refill();
    logic [LINE_BITS-1:0] ln;
    logic eh, fs, ok;
    logic [31:0] ew, d;
    ln = rand_line();
    model_access(21'h1111, 5'd9, 6'h3C, ln, eh, ew);
    fetch(21'h1111, 5'd9, 6'h3C, ln, 10, fs, d, ok);
    total_cnt++; if (fs !== 1'b1) $display("FAIL delay_miss got %0b want 1", fs); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1) $display("FAIL delay_req_stable got %0b want 1", ok); else pass_cnt++;
    total_cnt++; if (d !== ew) $display("FAIL delay_data got %h want %h", d, ew); else pass_cnt++;
  endtask

  task automatic test_random();
    logic eh, fs, ok;
    logic [31:0] ew, d;
    logic [TAG_W-1:0] t;
    logic [IDX_W-1:0] ix;
    logic [OFF_W-1:0] off;
    for (int i = 0; i < 40; i++) begin
      logic [LINE_BITS-1:0] ln;
      ln  = rand_line();
      t   = 21'h100 + 21'($urandom_range(0, 3));
      ix  = 5'd16 + 5'($urandom_range(0, 3));
      off = 6'($urandom_range(0, 63));
      model_access(t, ix, off, ln, eh, ew);
      fetch(t, ix, off, ln, $urandom_range(0, 3), fs, d, ok);
      total_cnt++; if (fs !== !eh) $display("FAIL rnd_stall[%0d] got %0b want %0b", i, fs, !eh); else pass_cnt++;
      total_cnt++; if (d !== ew) $display("FAIL rnd_data[%0d] got %h want %h", i, d, ew); else pass_cnt++;
      total_cnt++; if (ok !== 1'b1) $display("FAIL rnd_proto[%0d] got %0b want 1", i, ok); else pass_cnt++;
    end
    total_cnt++; if (bus.hit_count !== m_hits) $display("FAIL rnd_hits got %0d want %0d", bus.hit_count, m_hits); else pass_cnt++;
    total_cnt++; if (bus.miss_count !== m_misses) $display("FAIL rnd_misses got %0d want %0d", bus.miss_count, m_misses); else pass_cnt++;
  endtask

  task automatic test_flush_vs_refill();
    logic [LINE_BITS-1:0] ln1, ln2;
    logic eh;
    logic [31:0] ew;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    ln1 = rand_line();
    ln2 = rand_line();
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h2222; bus.index_C_L1 = 5'd7; bus.offset = 6'h04;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL flush_first_stall got %0b want 1", bus.stall); else pass_cnt++;
    tick();
    m_misses = m_misses + 32'd1;
    bus.ready_L2_L1 = 1'b1; bus.read_data_L2_L1 = ln1; bus.flush = 1'b1;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL flush_cycle_stall got %0b want 1", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.read_data_L1_C !== 32'h0) $display("FAIL flush_cycle_data got %h want 0", bus.read_data_L1_C); else pass_cnt++;
    tick();
    model_flush();
    bus.ready_L2_L1 = 1'b0; bus.read_data_L2_L1 = '0; bus.flush = 1'b0;
    #1;
    total_cnt++; if (bus.read_L1_L2 !== 1'b0) $display("FAIL flush_req_drop got %0b want 0", bus.read_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL flush_refetch_miss got %0b want 1", bus.stall); else pass_cnt++;
    model_access(21'h2222, 5'd7, 6'h04, ln2, eh, ew);
    tick();
    total_cnt++; if (bus.miss_count !== 32'd2) $display("FAIL flush_misses got %0d want 2", bus.miss_count); else pass_cnt++;
    bus.ready_L2_L1 = 1'b1; bus.read_data_L2_L1 = ln2;
    tick();
    bus.ready_L2_L1 = 1'b0; bus.read_data_L2_L1 = '0;
    #1;
    total_cnt++; if (bus.read_data_L1_C !== ew) $display("FAIL flush_refill_data got %h want %h", bus.read_data_L1_C, ew); else pass_cnt++;
    tick();
    bus.read_C_L1 = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    logic [LINE_BITS-1:0] ln;
    logic eh, fs, ok;
    logic [31:0] ew, d;
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h3333; bus.index_C_L1 = 5'd8; bus.offset = 6'h00;
    tick();
    #1;
    total_cnt++; if (bus.read_L1_L2 !== 1'b1) $display("FAIL rmiss_req got %0b want 1", bus.read_L1_L2); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.read_L1_L2 !== 1'b0) $display("FAIL rmiss_read_l2 got %0b want 0", bus.read_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL rmiss_stall got %0b want 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.tag_L1_L2 !== '0) $display("FAIL rmiss_tag got %h want 0", bus.tag_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.index_L1_L2 !== '0) $display("FAIL rmiss_idx got %h want 0", bus.index_L1_L2); else pass_cnt++;
    total_cnt++; if (bus.miss_count !== 32'd0) $display("FAIL rmiss_misses got %0d want 0", bus.miss_count); else pass_cnt++;
    tick();
    rst = 1'b0;
    bus.read_C_L1 = 1'b0;
    model_reset();
    tick();
    ln = rand_line();
    model_access(21'h2222, 5'd7, 6'h04, ln, eh, ew);
    fetch(21'h2222, 5'd7, 6'h04, ln, 0, fs, d, ok);
    total_cnt++; if (fs !== 1'b1) $display("FAIL rmiss_old_line_miss got %0b want 1", fs); else pass_cnt++;
    total_cnt++; if (d !== ew) $display("FAIL rmiss_data got %h want %h", d, ew); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic eh, fs, ok;
    logic [31:0] ew, d;
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.miss_cnt_q;
    m_misses = 32'hFFFF_FFFE;
    #1;
    total_cnt++; if (bus.miss_count !== 32'hFFFF_FFFE) $display("FAIL sat_preload got %h want fffffffe", bus.miss_count); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      logic [LINE_BITS-1:0] ln;
      ln = rand_line();
      model_access(21'h4444 + 21'(i), 5'd10, 6'h10, ln, eh, ew);
      fetch(21'h4444 + 21'(i), 5'd10, 6'h10, ln, 0, fs, d, ok);
      total_cnt++; if (bus.miss_count !== 32'hFFFF_FFFF) $display("FAIL sat_misses[%0d] got %h want ffffffff", i, bus.miss_count); else pass_cnt++;
      total_cnt++; if (bus.hit_count !== m_hits) $display("FAIL sat_hits[%0d] got %0d want %0d", i, bus.hit_count, m_hits); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_cold_fetch();
    test_plru();
    test_delayed_refill();
    test_random();
    test_flush_vs_refill();
    test_reset_mid_miss();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/l1_i_cache_param.md
L1_I_CACHE_PARAM -- requirements
Module: l1_i_cache_param

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-002 Parameter SETS, default 32, sets per way; power of two, 2..256.
REQ-003 Parameter LINE_BITS, default 512, line width; power of two, 64..1024.
REQ-004 Derived widths SHALL be: OFF_W=log2(LINE_BITS/8), IDX_W=log2(SETS), TAG_W=32-IDX_W-OFF_W, WSEL_W=log2(LINE_BITS/32).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 read_C_L1  in  1  core fetch request; held stable by core while stall=1.
REQ-008 tag_C_L1  in  TAG_W  fetch tag.
REQ-009 index_C_L1  in  IDX_W  fetch set index.
REQ-010 offset  in  OFF_W  byte offset; offset[OFF_W-1:2] selects word, offset[1:0] ignored.
REQ-011 flush  in  1  invalidate entire cache.
REQ-012 stall  out  1  fetch not satisfied this cycle.
REQ-013 read_data_L1_C  out  32  fetched instruction word.
REQ-014 read_L1_L2  out  1  line refill request to L2.
REQ-015 tag_L1_L2  out  TAG_W; index_L1_L2  out  IDX_W  refill line address.
REQ-016 ready_L2_L1  in  1  L2 line valid on read_data_L2_L1 this cycle.
REQ-017 read_data_L2_L1  in  LINE_BITS  refill line.
REQ-018 hit_count  out  32; miss_count  out  32  saturating performance counters.

Function
REQ-019 Storage SHALL be WAYS x SETS entries of {valid, tag, line}, plus (WAYS-1)-bit tree-PLRU state per set (no PLRU state when WAYS=1).
REQ-020 FSM SHALL have states IDLE and MISS; only these two.
REQ-021 In IDLE, hit = read_C_L1 and some way at index_C_L1 valid with matching tag; lookup and word select SHALL be combinational (zero-cycle hit latency).
REQ-022 On hit: stall=0, read_data_L1_C = selected word of hit way; PLRU of that set updated to mark hit way most-recent at the clock edge.
REQ-023 On IDLE miss (read_C_L1=1, no hit): stall=1 that cycle; tag/index latched; FSM -> MISS.
REQ-024 In MISS: stall=1, read_L1_L2=1, tag_L1_L2/index_L1_L2 = latched values, held stable until ready_L2_L1 sampled 1.
REQ-025 In MISS with ready_L2_L1=1: line written to victim way, valid set, tag written, PLRU updated as for a hit, FSM -> IDLE; re-presented request then hits next cycle.
REQ-026 Victim = lowest-numbered invalid way in the set; if all valid, the PLRU-indicated way; victim chosen at MISS entry.
REQ-027 read_L1_L2 SHALL be 0 in IDLE; tag_L1_L2/index_L1_L2 hold last latched value.
REQ-028 read_data_L1_C SHALL be 0 whenever stall=1 or read_C_L1=0.
REQ-029 hit_count +1 per IDLE hit cycle; miss_count +1 per IDLE->MISS transition; both saturate at 0xFFFFFFFF.
REQ-030 flush=1 in any state: all valid bits and PLRU cleared at the edge, FSM -> IDLE, outstanding refill abandoned (read_L1_L2 drops next cycle, ready_L2_L1 in that cycle ignored); stall=1 during a flush cycle; counters unaffected.
REQ-031 flush and ready_L2_L1 in same MISS cycle: flush wins, no line written.
REQ-032 read_C_L1=0 in IDLE: stall=0, no state change, no counter change.

Reset
REQ-033 While rst=1: FSM=IDLE, all valid=0, PLRU=0, latched tag/index=0, counters=0; outputs stall=0, read_L1_L2=0, read_data_L1_C=0, tag_L1_L2=0, index_L1_L2=0.
REQ-034 rst asserted during MISS SHALL abandon the refill immediately (asynchronously) with the REQ-033 values.

Verification (WAYS=2, SETS=32, LINE_BITS=512)
REQ-035 Cold fetch tag=0x1234, idx=3, offset=0x08 -> stall=1, read_L1_L2=1 next cycle with tag/idx echoed; ready with line word2=0xDEADBEEF -> next cycle stall=0, data=0xDEADBEEF, miss_count=1, hit_count=1.
REQ-036 Fill idx 5 with tags A, B; hit A; miss C -> C replaces B (PLRU); refetch A hits, B misses.
REQ-037 ready_L2_L1 delayed 10 cycles -> read_L1_L2 and address stable for all 10 cycles, stall=1 throughout.
REQ-038 flush during MISS with ready same cycle -> no write, FSM IDLE, refetch misses again, miss_count=2.
REQ-039 rst pulse mid-MISS -> all outputs 0 immediately; prior cached line misses after reset.
REQ-040 Force miss_count to 0xFFFFFFFF via 2^32-equivalent preload (white-box) -> further miss leaves 0xFFFFFFFF.
